// File: rtl/mms_pkg.sv
// ---------------------------------------------------------------------------
// mms_pkg -- shared types for the memory-management slice.
//
// Contents:
//   vpn_t                 virtual page number (Sv39, 27 bits)
//   itlb_refill_state_e   ITLB refill controller states
//   itlb_plru_wd()        tree pseudo-LRU width for a given entry count
//   ITLB_PLRU_WD          tree pseudo-LRU width for the default entry count
//
// Build macros (defaults given here if the build does not supply them):
//   TLB_ENTRY_NUM   default ITLB entry count
//   ASID_WD         address-space identifier width
// ---------------------------------------------------------------------------
`ifndef TLB_ENTRY_NUM
`define TLB_ENTRY_NUM 4
`endif
`ifndef ASID_WD
`define ASID_WD 16
`endif

package mms_pkg;

  localparam int VPN_WD = 27;
  typedef logic [VPN_WD-1:0] vpn_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FILL  = 3'd3,
    DRAIN = 3'd4
  } itlb_refill_state_e;

  // A binary tree over n leaves has n-1 internal nodes, one bit each.
  function automatic int itlb_plru_wd(input int n);
    return n - 1;
  endfunction

  localparam int ITLB_PLRU_WD = itlb_plru_wd(`TLB_ENTRY_NUM);

endpackage

// File: rtl/itlb_victim_sel.sv
// ---------------------------------------------------------------------------
// itlb_victim_sel -- picks the ITLB entry to overwrite on a refill.
//
// The lowest-index entry that has not been filled since reset/flush wins.
// When every entry is valid the replacement policy decides:
//   default         round-robin pointer, advanced once per committed fill
//   ITLB_PLRU_EN    tree pseudo-LRU, touched by every hit lookup and fill
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   flush_i         return the policy state to its reset value
//   valid_i         per-entry "filled since flush" bits
//   fill_i          a fill is committed this cycle at fill_idx_i
//   hit_i           a hit lookup is committed this cycle at hit_idx_i
//   victim_idx_o    entry to use for the next fill
// ---------------------------------------------------------------------------
`ifndef TLB_ENTRY_NUM
`define TLB_ENTRY_NUM 4
`endif

module itlb_victim_sel
  import mms_pkg::*;
#(
  parameter  int ENTRY_NUM = `TLB_ENTRY_NUM,
  localparam int IDX_WD    = $clog2(ENTRY_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 flush_i,
  input  logic [ENTRY_NUM-1:0] valid_i,
  input  logic                 fill_i,
  input  logic [IDX_WD-1:0]    fill_idx_i,
  input  logic                 hit_i,
  input  logic [IDX_WD-1:0]    hit_idx_i,
  output logic [IDX_WD-1:0]    victim_idx_o
);

  logic              inv_found;
  logic [IDX_WD-1:0] inv_idx;
  logic [IDX_WD-1:0] policy_idx;

  // Scanning from the top down leaves the lowest invalid index behind.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_WD'(i);
      end
    end
  end

  assign victim_idx_o = inv_found ? inv_idx : policy_idx;

`ifdef ITLB_PLRU_EN
  localparam int PLRU_WD = itlb_plru_wd(ENTRY_NUM);

  logic [PLRU_WD-1:0] plru_q;
  logic [PLRU_WD-1:0] plru_d;

  // Node k has children 2k+1 / 2k+2; a 0 bit means the victim lies left.
  // Touching an entry points every node on its path at the other half.
  function automatic logic [PLRU_WD-1:0] plru_touch(
    input logic [PLRU_WD-1:0] tree,
    input logic [IDX_WD-1:0]  idx
  );
    logic [PLRU_WD-1:0] t;
    int                 node;
    logic               dir;
    t    = tree;
    node = 0;
    for (int lvl = 0; lvl < IDX_WD; lvl++) begin
      dir     = idx[IDX_WD-1-lvl];
      t[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return t;
  endfunction

  function automatic logic [IDX_WD-1:0] plru_pick(input logic [PLRU_WD-1:0] tree);
    int node;
    node = 0;
    for (int lvl = 0; lvl < IDX_WD; lvl++) begin
      node = 2 * node + 1 + int'(tree[node]);
    end
    return IDX_WD'(node - (ENTRY_NUM - 1));
  endfunction

  // A fill and a hit can land in the same cycle; the hit is applied last.
  always_comb begin
    plru_d = plru_q;
    if (fill_i) plru_d = plru_touch(plru_d, fill_idx_i);
    if (hit_i)  plru_d = plru_touch(plru_d, hit_idx_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      plru_q <= '0;
    else if (flush_i) plru_q <= '0;
    else              plru_q <= plru_d;
  end

  assign policy_idx = plru_pick(plru_q);
`else
  logic [IDX_WD-1:0] rr_q;
  logic              unused_policy_in;

  // Entry count is a power of two, so the pointer wraps on its own.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      rr_q <= '0;
    else if (flush_i) rr_q <= '0;
    else if (fill_i)  rr_q <= rr_q + 1'b1;
  end

  assign policy_idx       = rr_q;
  assign unused_policy_in = hit_i ^ (^hit_idx_i) ^ (^fill_idx_i);
`endif

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ---------------------------------------------------------------------------
// itlb_refill_ctrl -- ITLB miss handling: page-walk request, response wait,
// and a one-cycle fill strobe into the tag array.
//
// Build macro: ITLB_PLRU_EN selects tree pseudo-LRU replacement instead of
// the default round-robin pointer.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   tlb_flush_i          drop all ITLB state including an in-flight refill
//   lookup_valid_i       lookup this cycle (lookup_vpn_i, asid_i)
//   itlb_entry_hit_i     per-entry hit vector from the tag array
//   ptw_req_*            page-walk request (valid/ready, VPN, ASID)
//   ptw_resp_valid_i     page-walk response, ptw_resp_fault_i marks a fault
//   write_en_o           one-hot fill strobe
//   miss_busy_o          refill in progress
//   fault_o              one-cycle page-fault pulse
// ---------------------------------------------------------------------------
`ifndef TLB_ENTRY_NUM
`define TLB_ENTRY_NUM 4
`endif
`ifndef ASID_WD
`define ASID_WD 16
`endif

module itlb_refill_ctrl
  import mms_pkg::*;
#(
  parameter int ENTRY_NUM = `TLB_ENTRY_NUM
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tlb_flush_i,
  input  logic                 lookup_valid_i,
  input  vpn_t                 lookup_vpn_i,
  input  logic [`ASID_WD-1:0]  asid_i,
  input  logic [ENTRY_NUM-1:0] itlb_entry_hit_i,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output vpn_t                 ptw_req_vpn_o,
  output logic [`ASID_WD-1:0]  ptw_req_asid_o,
  input  logic                 ptw_resp_valid_i,
  input  logic                 ptw_resp_fault_i,
  output logic [ENTRY_NUM-1:0] write_en_o,
  output logic                 miss_busy_o,
  output logic                 fault_o
);

  localparam int IDX_WD = $clog2(ENTRY_NUM);

  itlb_refill_state_e state_q, state_d;

  vpn_t                 vpn_q;
  logic [`ASID_WD-1:0]  asid_q;
  logic [ENTRY_NUM-1:0] valid_q;
  logic [IDX_WD-1:0]    victim_q;
  logic [IDX_WD-1:0]    victim_idx;
  logic [IDX_WD-1:0]    hit_idx;
  logic                 fault_q;

  logic lookup_hit;
  logic miss_start;
  logic hit_commit;
  logic enter_fill;
  logic fill_commit;
  logic fault_set;

  // A flush in any state wins over whatever the same cycle would commit.
  assign lookup_hit  = |itlb_entry_hit_i;
  assign miss_start  = (state_q == IDLE) && lookup_valid_i && !lookup_hit && !tlb_flush_i;
  assign hit_commit  = (state_q == IDLE) && lookup_valid_i &&  lookup_hit && !tlb_flush_i;
  assign enter_fill  = (state_q == WAIT) && ptw_resp_valid_i && !ptw_resp_fault_i && !tlb_flush_i;
  assign fault_set   = (state_q == WAIT) && ptw_resp_valid_i &&  ptw_resp_fault_i && !tlb_flush_i;
  assign fill_commit = (state_q == FILL) && !tlb_flush_i;

  // Lowest set bit of the hit vector names the touched entry.
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (itlb_entry_hit_i[i]) hit_idx = IDX_WD'(i);
    end
  end

  itlb_victim_sel #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_victim_sel (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (tlb_flush_i),
    .valid_i      (valid_q),
    .fill_i       (fill_commit),
    .fill_idx_i   (victim_q),
    .hit_i        (hit_commit),
    .hit_idx_i    (hit_idx),
    .victim_idx_o (victim_idx)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request payload, victim and fault pulse are all registered so the
  // page-walk request stays stable while it waits for ready.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vpn_q    <= '0;
      asid_q   <= '0;
      victim_q <= '0;
      fault_q  <= 1'b0;
      valid_q  <= '0;
    end else begin
      fault_q <= fault_set;
      if (miss_start) begin
        vpn_q  <= lookup_vpn_i;
        asid_q <= asid_i;
      end
      if (enter_fill) victim_q <= victim_idx;
      if (tlb_flush_i)      valid_q           <= '0;
      else if (fill_commit) valid_q[victim_q] <= 1'b1;
    end
  end

  // A handshake that completes in the same cycle as a flush leaves a walk
  // outstanding, so its response still has to be drained.
  always_comb begin
    state_d         = state_q;
    ptw_req_valid_o = (state_q == REQ);
    miss_busy_o     = (state_q != IDLE);
    fault_o         = fault_q;
    write_en_o      = '0;
    if (fill_commit) write_en_o[victim_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (miss_start) state_d = REQ;
      end
      REQ: begin
        if (ptw_req_ready_i)  state_d = tlb_flush_i ? DRAIN : WAIT;
        else if (tlb_flush_i) state_d = IDLE;
      end
      WAIT: begin
        if (ptw_resp_valid_i)  state_d = (tlb_flush_i || ptw_resp_fault_i) ? IDLE : FILL;
        else if (tlb_flush_i)  state_d = DRAIN;
      end
      FILL: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (ptw_resp_valid_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ptw_req_vpn_o  = vpn_q;
  assign ptw_req_asid_o = asid_q;

endmodule
